// File: rtl/regfile_16_pkg.sv
// Shared constants and the write/claim address decoder for the 16-entry register file.
package regfile_16_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;
   localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;

   // One-hot decode with entry 0 masked off, so r0 can never be written or claimed.
   function automatic logic [NUM_REGS-1:0] decode_nz(input logic en,
                                                      input logic [ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] hot;
      hot = '0;
      if (en) begin
         hot[addr] = 1'b1;
      end
      hot[ZERO_REG] = 1'b0;
      return hot;
   endfunction

endpackage

// File: rtl/regfile_16_mux_16.sv
// Sixteen-way select shared by the data and busy read paths.
module mux_16 #(
   parameter int W = 32
) (
   input  logic [3:0]   sel,
   input  logic [W-1:0] din [16],
   output logic [W-1:0] dout
);

   assign dout = din[sel];

endmodule

// File: rtl/regfile_16_reg32.sv
// Storage element for one register-file entry: enable-gated load, synchronous clear.
module reg32
   import regfile_16_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_16.sv
// 16 x 32 register file: two combinational read ports with write bypass, one write
// port, and a pending bit per register set by claims and cleared by writes.
module regfile_16 #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ctrl_writeEnable,
   input  logic [3:0]        ctrl_writeReg,
   input  logic [DATA_W-1:0] data_writeReg,
   input  logic              ctrl_claim,
   input  logic [3:0]        ctrl_claimReg,
   input  logic [3:0]        ctrl_readRegA,
   input  logic [3:0]        ctrl_readRegB,
   output logic [DATA_W-1:0] data_readRegA,
   output logic [DATA_W-1:0] data_readRegB,
   output logic              busyA,
   output logic              busyB
);
   import regfile_16_pkg::*;

   logic [NUM_REGS-1:0] write_hot;
   logic [NUM_REGS-1:0] claim_hot;
   logic [DATA_W-1:0]   regs     [NUM_REGS];
   logic [0:0]          pend_sel [NUM_REGS];
   logic [NUM_REGS-1:1] pend;
   logic [DATA_W-1:0]   stored_a, stored_b;
   logic [0:0]          pend_a, pend_b;
   logic                write_live, bypass_a, bypass_b;

   // Reset gates both decoders, which suppresses writes, claims and the bypass together.
   assign write_live = ctrl_writeEnable && !reset && (ctrl_writeReg != ZERO_REG);
   assign write_hot  = decode_nz(ctrl_writeEnable && !reset, ctrl_writeReg);
   assign claim_hot  = decode_nz(ctrl_claim && !reset, ctrl_claimReg);

   assign regs[0]     = '0;
   assign pend_sel[0] = 1'b0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
      reg32 #(.W(DATA_W)) u_reg (
         .clock (clock),
         .reset (reset),
         .en    (write_hot[i]),
         .d     (data_writeReg),
         .q     (regs[i])
      );
      assign pend_sel[i] = pend[i];
   end

   // Claim is applied after the write clear, so a same-register claim leaves the bit set.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~write_hot[NUM_REGS-1:1]) | claim_hot[NUM_REGS-1:1];
      end
   end

   mux_16 #(.W(DATA_W)) u_mux_data_a (.sel(ctrl_readRegA), .din(regs),     .dout(stored_a));
   mux_16 #(.W(DATA_W)) u_mux_data_b (.sel(ctrl_readRegB), .din(regs),     .dout(stored_b));
   mux_16 #(.W(1))      u_mux_busy_a (.sel(ctrl_readRegA), .din(pend_sel), .dout(pend_a));
   mux_16 #(.W(1))      u_mux_busy_b (.sel(ctrl_readRegB), .din(pend_sel), .dout(pend_b));

   assign bypass_a = write_live && (ctrl_writeReg == ctrl_readRegA);
   assign bypass_b = write_live && (ctrl_writeReg == ctrl_readRegB);

   // A bypassed read shows the incoming data and the pending state it will have after the edge.
   assign data_readRegA = bypass_a ? data_writeReg : stored_a;
   assign data_readRegB = bypass_b ? data_writeReg : stored_b;
   assign busyA         = bypass_a ? claim_hot[ctrl_readRegA] : pend_a[0];
   assign busyB         = bypass_b ? claim_hot[ctrl_readRegB] : pend_b[0];

endmodule
